// File: rtl/mem_pkg.sv
// Shared encodings for the byte-lane data memory and its front-end arbiter.
package mem_pkg;

  // Write-mask encoding understood by the memory: none / byte / half / word.
  localparam logic [1:0] WRMASK_N = 2'd0;
  localparam logic [1:0] WRMASK_B = 2'd1;
  localparam logic [1:0] WRMASK_H = 2'd2;
  localparam logic [1:0] WRMASK_W = 2'd3;

  // Read-mask encoding: word, half zero-ext, byte zero-ext, half sign-ext,
  // byte sign-ext, no read.
  localparam logic [2:0] RDMASK_W  = 3'd0;
  localparam logic [2:0] RDMASK_HZ = 3'd1;
  localparam logic [2:0] RDMASK_BZ = 3'd2;
  localparam logic [2:0] RDMASK_HE = 3'd3;
  localparam logic [2:0] RDMASK_BE = 3'd4;
  localparam logic [2:0] RDMASK_XX = 3'd5;

  typedef enum logic [1:0] {
    SZ_B = 2'd0,
    SZ_H = 2'd1,
    SZ_W = 2'd2,
    SZ_X = 2'd3
  } size_e;

  typedef enum logic [1:0] {
    ERR_NONE     = 2'd0,
    ERR_MISALIGN = 2'd1,
    ERR_RANGE    = 2'd2,
    ERR_SIZE     = 2'd3
  } err_e;

  // Store width to write mask; an invalid size never reaches memory.
  function automatic logic [1:0] size_to_wrmask(input size_e sz);
    case (sz)
      SZ_B:    return WRMASK_B;
      SZ_H:    return WRMASK_H;
      SZ_W:    return WRMASK_W;
      default: return WRMASK_N;
    endcase
  endfunction

  // Load width and signedness to read mask; signedness only matters below word.
  function automatic logic [2:0] load_to_rdmask(input size_e sz, input logic sign_ext);
    case (sz)
      SZ_B:    return sign_ext ? RDMASK_BE : RDMASK_BZ;
      SZ_H:    return sign_ext ? RDMASK_HE : RDMASK_HZ;
      SZ_W:    return RDMASK_W;
      default: return RDMASK_XX;
    endcase
  endfunction

endpackage

// File: rtl/mem_req_decode.sv
// Legality checks and mask translation for the single request that won
// arbitration this cycle. Purely combinational.
module mem_req_decode
  import mem_pkg::*;
#(
  parameter int unsigned MEM_BYTES = 4096
) (
  input  logic        is_fetch_i,
  input  logic        we_i,
  input  logic [1:0]  size_i,
  input  logic        sign_ext_i,
  input  logic [31:0] addr_i,
  output logic [1:0]  wr_mask_o,
  output logic [2:0]  rd_mask_o,
  output err_e        err_o
);

  size_e size_eff;
  err_e  err_d;

  // Fetches are always word reads regardless of the data-port size field.
  assign size_eff = is_fetch_i ? SZ_W : size_e'(size_i);

  // Classify the request; invalid size beats misalignment beats range.
  always_comb begin
    err_d = ERR_NONE;
    if (size_eff == SZ_X) begin
      err_d = ERR_SIZE;
    end else if ((size_eff == SZ_W && addr_i[1:0] != 2'b00) ||
                 (size_eff == SZ_H && addr_i[0])) begin
      err_d = ERR_MISALIGN;
    end else if (addr_i >= 32'(MEM_BYTES)) begin
      err_d = ERR_RANGE;
    end
  end

  // Translate a legal request into memory masks; anything illegal stays idle.
  always_comb begin
    wr_mask_o = WRMASK_N;
    rd_mask_o = RDMASK_XX;
    if (err_d == ERR_NONE) begin
      if (is_fetch_i) begin
        rd_mask_o = RDMASK_W;
      end else if (we_i) begin
        wr_mask_o = size_to_wrmask(size_eff);
      end else begin
        rd_mask_o = load_to_rdmask(size_eff, sign_ext_i);
      end
    end
  end

  assign err_o = err_d;

endmodule

// File: rtl/mem_arbiter.sv
// Two-port arbiter in front of the byte-lane data memory: data port has
// priority, fetch is protected from starvation by a saturating wait counter.
// Responses come back one cycle after the grant, routed to the granted port.
module mem_arbiter
  import mem_pkg::*;
#(
  parameter int unsigned MEM_BYTES      = 4096,
  parameter int unsigned FETCH_MAX_WAIT = 4
) (
  input  logic        i_clk,
  input  logic        i_reset,
  input  logic        i_if_req,
  input  logic [31:0] i_if_addr,
  output logic        o_if_gnt,
  output logic        o_if_rvalid,
  output logic [31:0] o_if_rdata,
  output logic [1:0]  o_if_err,
  input  logic        i_dm_req,
  input  logic        i_dm_we,
  input  logic [1:0]  i_dm_size,
  input  logic        i_dm_signed,
  input  logic [31:0] i_dm_addr,
  input  logic [31:0] i_dm_wdata,
  output logic        o_dm_gnt,
  output logic        o_dm_rvalid,
  output logic [31:0] o_dm_rdata,
  output logic [1:0]  o_dm_err,
  output logic [31:0] o_mem_address,
  output logic [31:0] o_mem_wr_data,
  output logic [1:0]  o_mem_wr_mask,
  output logic [2:0]  o_mem_rd_mask,
  input  logic [31:0] i_mem_rd_data
);

  localparam int unsigned WAIT_W = (FETCH_MAX_WAIT < 1) ? 1 : $clog2(FETCH_MAX_WAIT + 1);
  localparam logic [WAIT_W-1:0] WAIT_MAX = WAIT_W'(FETCH_MAX_WAIT);

  // Registered state
  logic [WAIT_W-1:0] wait_q, wait_d;
  logic              if_rvalid_q, if_rvalid_d;
  logic              dm_rvalid_q, dm_rvalid_d;
  err_e              rsp_err_q, rsp_err_d;
  logic              rsp_data_q, rsp_data_d;

  // Arbitration and decode
  logic        fetch_starved;
  logic        if_gnt;
  logic        dm_gnt;
  logic        any_gnt;
  logic [31:0] req_addr;
  logic [1:0]  dec_wr_mask;
  logic [2:0]  dec_rd_mask;
  err_e        dec_err;
  logic        rsp_live;

  // Pick at most one requester; nothing is granted while reset is held.
  always_comb begin
    fetch_starved = (wait_q == WAIT_MAX);
    if_gnt        = 1'b0;
    dm_gnt        = 1'b0;
    if (!i_reset) begin
      if_gnt = i_if_req && (fetch_starved || !i_dm_req);
      dm_gnt = i_dm_req && !if_gnt;
    end
    any_gnt  = if_gnt || dm_gnt;
    req_addr = if_gnt ? i_if_addr : i_dm_addr;
  end

  mem_req_decode #(
    .MEM_BYTES (MEM_BYTES)
  ) u_decode (
    .is_fetch_i (if_gnt),
    .we_i       (i_dm_we),
    .size_i     (i_dm_size),
    .sign_ext_i (i_dm_signed),
    .addr_i     (req_addr),
    .wr_mask_o  (dec_wr_mask),
    .rd_mask_o  (dec_rd_mask),
    .err_o      (dec_err)
  );

  // Drive memory only for a legal granted access; otherwise hold it idle.
  always_comb begin
    o_mem_address = 32'd0;
    o_mem_wr_data = 32'd0;
    o_mem_wr_mask = WRMASK_N;
    o_mem_rd_mask = RDMASK_XX;
    if (any_gnt && dec_err == ERR_NONE) begin
      o_mem_address = req_addr;
      o_mem_wr_data = if_gnt ? 32'd0 : i_dm_wdata;
      o_mem_wr_mask = dec_wr_mask;
      o_mem_rd_mask = dec_rd_mask;
    end
  end

  // Next state: starvation counter and the one-deep response pipeline.
  always_comb begin
    wait_d = wait_q;
    if (!i_if_req || if_gnt) begin
      wait_d = '0;
    end else if (!fetch_starved) begin
      wait_d = wait_q + 1'b1;
    end
    if_rvalid_d = if_gnt;
    dm_rvalid_d = dm_gnt;
    rsp_err_d   = any_gnt ? dec_err : ERR_NONE;
    // Only legal fetches and loads forward memory read data.
    rsp_data_d  = any_gnt && (dec_err == ERR_NONE) && (if_gnt || !i_dm_we);
  end

  // State registers with synchronous reset.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      wait_q      <= '0;
      if_rvalid_q <= 1'b0;
      dm_rvalid_q <= 1'b0;
      rsp_err_q   <= ERR_NONE;
      rsp_data_q  <= 1'b0;
    end else begin
      wait_q      <= wait_d;
      if_rvalid_q <= if_rvalid_d;
      dm_rvalid_q <= dm_rvalid_d;
      rsp_err_q   <= rsp_err_d;
      rsp_data_q  <= rsp_data_d;
    end
  end

  // Responses: a response already queued when reset arrives is suppressed.
  always_comb begin
    rsp_live    = !i_reset;
    o_if_gnt    = if_gnt;
    o_dm_gnt    = dm_gnt;
    o_if_rvalid = if_rvalid_q && rsp_live;
    o_dm_rvalid = dm_rvalid_q && rsp_live;
    o_if_err    = o_if_rvalid ? rsp_err_q : ERR_NONE;
    o_dm_err    = o_dm_rvalid ? rsp_err_q : ERR_NONE;
    o_if_rdata  = (o_if_rvalid && rsp_data_q) ? i_mem_rd_data : 32'd0;
    o_dm_rdata  = (o_dm_rvalid && rsp_data_q) ? i_mem_rd_data : 32'd0;
  end

endmodule
